// File: rtl/register_bank_sb_pkg.sv
// Shared constants and types for the register bank with pending-write scoreboard.
// Used by register_bank_sb, its interface and the regbank_scoreboard sub-module.
package regbank_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

    localparam logic [DEFAULT_DATA_W-1:0] RESET_VAL = '0;

    // True when the address selects register 0 and that register is hardwired to zero.
    function automatic logic is_zero_reg(input logic zero_r0, input logic [31:0] addr);
        return zero_r0 && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/register_bank_sb_if.sv
// Decode/issue/writeback bus of the register bank: two read ports with hazard
// flags, one write port and one issue port.
interface register_bank_sb_if
    import regbank_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
);

    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic [DATA_W-1:0] PRA;
    logic [DATA_W-1:0] PRB;
    logic              HZ_A;
    logic              HZ_B;
    logic              W_RB;
    logic [ADDR_W-1:0] WC;
    logic [DATA_W-1:0] WPC;
    logic              ISSUE;
    logic [ADDR_W-1:0] ID;

    modport master (
        output RA, RB, W_RB, WC, WPC, ISSUE, ID,
        input  PRA, PRB, HZ_A, HZ_B
    );

    modport slave (
        input  RA, RB, W_RB, WC, WPC, ISSUE, ID,
        output PRA, PRB, HZ_A, HZ_B
    );

endinterface

// File: rtl/register_bank_sb_scoreboard.sv
// Pending-write scoreboard: one flag per register, set by issue, cleared by
// writeback, issue wins on the same register; two combinational lookup ports.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter  int DEPTH   = DEFAULT_DEPTH,
    parameter  int ZERO_R0 = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] lk_a,
    input  logic [ADDR_W-1:0] lk_b,
    output logic              pend_a,
    output logic              pend_b
);

    localparam logic Z0 = (ZERO_R0 != 0);

    logic [DEPTH-1:0] pend;
    logic             set_ok;

    assign set_ok = set_en && !is_zero_reg(Z0, 32'(set_idx));

    // The set is applied after the clear so a same-register issue keeps the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (clr_en) begin
                pend[clr_idx] <= 1'b0;
            end
            if (set_ok) begin
                pend[set_idx] <= 1'b1;
            end
        end
    end

    assign pend_a = pend[lk_a];
    assign pend_b = pend[lk_b];

endmodule

// File: rtl/register_bank_sb.sv
// Parametrised register bank: two async read ports with hazard flags, one sync
// write port, pending scoreboard. Optional macro REGBANK_BYPASS_EN forwards WPC.
module register_bank_sb
    import regbank_pkg::*;
#(
    parameter  int DATA_W  = DEFAULT_DATA_W,
    parameter  int DEPTH   = DEFAULT_DEPTH,
    parameter  int ZERO_R0 = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input logic               CLK,
    input logic               RST,
    register_bank_sb_if.slave bus
);

    localparam logic Z0 = (ZERO_R0 != 0);

    if ((DEPTH < 2) || ((1 << ADDR_W) != DEPTH)) begin : g_bad_depth
        $error("register_bank_sb: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;
    logic              pend_a;
    logic              pend_b;
    logic [DATA_W-1:0] pra;
    logic [DATA_W-1:0] prb;
    logic              hz_a;
    logic              hz_b;

    assign wr_ok = bus.W_RB && !is_zero_reg(Z0, 32'(bus.WC));

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= DATA_W'(RESET_VAL);
            end
        end else if (wr_ok) begin
            regs[bus.WC] <= bus.WPC;
        end
    end

    regbank_scoreboard #(
        .DEPTH   (DEPTH),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk     (CLK),
        .rst     (RST),
        .set_en  (bus.ISSUE),
        .set_idx (bus.ID),
        .clr_en  (bus.W_RB),
        .clr_idx (bus.WC),
        .lk_a    (bus.RA),
        .lk_b    (bus.RB),
        .pend_a  (pend_a),
        .pend_b  (pend_b)
    );

    always_comb begin
        pra  = regs[bus.RA];
        prb  = regs[bus.RB];
        hz_a = pend_a;
        hz_b = pend_b;
`ifdef REGBANK_BYPASS_EN
        // Forward the in-flight writeback; a same-cycle issue only shows after the edge.
        if (wr_ok && (bus.WC == bus.RA)) begin
            pra  = bus.WPC;
            hz_a = 1'b0;
        end
        if (wr_ok && (bus.WC == bus.RB)) begin
            prb  = bus.WPC;
            hz_b = 1'b0;
        end
`endif
        if (is_zero_reg(Z0, 32'(bus.RA))) begin
            pra  = '0;
            hz_a = 1'b0;
        end
        if (is_zero_reg(Z0, 32'(bus.RB))) begin
            prb  = '0;
            hz_b = 1'b0;
        end
    end

    assign bus.PRA  = pra;
    assign bus.PRB  = prb;
    assign bus.HZ_A = hz_a;
    assign bus.HZ_B = hz_b;

endmodule
